// File: rtl/sc_reg_lives_manager.sv
// sc_reg_lives_manager
// Player lives register for the game datapath. Holds the life count and
// supports clear-to-initial, parallel load, lose-life and bonus-life. Each
// non-final lost life opens a timed invulnerability (grace) window during
// which further lose-life requests are ignored.
//
// Ports:
//   RegLIVES_CLOCK_50            clock, rising edge
//   RegLIVES_RESET_InLow         synchronous reset, active low
//   RegLIVES_clear_InLow         reload LIVES_INIT (highest priority)
//   RegLIVES_load_InLow          load RegLIVES_data_InBUS (saturated to LIVES_MAX)
//   RegLIVES_data_InBUS          load value
//   RegLIVES_subtract_life_InLow lose-life request, level sensitive
//   RegLIVES_add_life_InLow      bonus-life request, level sensitive
//   RegLIVES_data_OutBUS         current life count (registered)
//   RegLIVES_gameover_OutLow     0 when the count is 0
//   RegLIVES_grace_OutHigh       1 while the grace window is running
//   RegLIVES_lifelost_OutHigh    one-cycle pulse per accepted decrement
module sc_reg_lives_manager #(
  parameter int LIVES_WIDTH  = 3,
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_MAX    = 7,
  parameter int GRACE_WIDTH  = 8,
  parameter int GRACE_CYCLES = 200
) (
  input  logic                   RegLIVES_CLOCK_50,
  input  logic                   RegLIVES_RESET_InLow,
  input  logic                   RegLIVES_clear_InLow,
  input  logic                   RegLIVES_load_InLow,
  input  logic [LIVES_WIDTH-1:0] RegLIVES_data_InBUS,
  input  logic                   RegLIVES_subtract_life_InLow,
  input  logic                   RegLIVES_add_life_InLow,
  output logic [LIVES_WIDTH-1:0] RegLIVES_data_OutBUS,
  output logic                   RegLIVES_gameover_OutLow,
  output logic                   RegLIVES_grace_OutHigh,
  output logic                   RegLIVES_lifelost_OutHigh
);

  typedef enum logic [1:0] {
    ST_GAMEOVER = 2'd0,
    ST_ALIVE    = 2'd1,
    ST_GRACE    = 2'd2
  } state_t;

  localparam logic [LIVES_WIDTH-1:0] INIT_V     = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] MAX_V      = LIVES_WIDTH'(LIVES_MAX);
  localparam logic [LIVES_WIDTH-1:0] ONE_LIFE   = LIVES_WIDTH'(1);
  localparam logic [LIVES_WIDTH-1:0] ZERO_LIFE  = {LIVES_WIDTH{1'b0}};
  // The counter counts down to zero, so a window of N cycles loads N-1.
  localparam logic [GRACE_WIDTH-1:0] GRACE_LOAD = GRACE_WIDTH'(GRACE_CYCLES - 1);
  localparam logic [GRACE_WIDTH-1:0] GRACE_ZERO = {GRACE_WIDTH{1'b0}};
  localparam logic [GRACE_WIDTH-1:0] GRACE_ONE  = GRACE_WIDTH'(1);

  state_t                 state_r, state_s;
  logic [LIVES_WIDTH-1:0] count_r, count_s;
  logic [GRACE_WIDTH-1:0] grace_cnt_r, grace_cnt_s;
  logic                   lifelost_r, lifelost_s;
  logic                   gameover_r, gameover_s;
  logic                   grace_r, grace_s;
  logic [LIVES_WIDTH-1:0] load_sat_s;

  // Next-state and next-count logic: grace timer first, then requests in priority order.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    grace_cnt_s = grace_cnt_r;
    lifelost_s  = 1'b0;
    load_sat_s  = (RegLIVES_data_InBUS > MAX_V) ? MAX_V : RegLIVES_data_InBUS;

    // The grace timer runs on its own; only clear/load below can abort it.
    if (state_r == ST_GRACE) begin
      if (grace_cnt_r == GRACE_ZERO) begin
        state_s = ST_ALIVE;
      end else begin
        grace_cnt_s = grace_cnt_r - GRACE_ONE;
      end
    end else begin
      grace_cnt_s = grace_cnt_r;
    end

    // An asserted higher-priority request masks lower ones even when it is
    // itself ignored in the current state (e.g. subtract during grace).
    if (!RegLIVES_clear_InLow) begin
      count_s     = INIT_V;
      state_s     = ST_ALIVE;
      grace_cnt_s = GRACE_ZERO;
    end else if (!RegLIVES_load_InLow) begin
      count_s     = load_sat_s;
      state_s     = (load_sat_s == ZERO_LIFE) ? ST_GAMEOVER : ST_ALIVE;
      grace_cnt_s = GRACE_ZERO;
    end else if (!RegLIVES_subtract_life_InLow) begin
      if (state_r == ST_ALIVE) begin
        count_s    = count_r - ONE_LIFE;
        lifelost_s = 1'b1;
        if (count_r == ONE_LIFE) begin
          state_s     = ST_GAMEOVER;
          grace_cnt_s = GRACE_ZERO;
        end else begin
          state_s     = ST_GRACE;
          grace_cnt_s = GRACE_LOAD;
        end
      end else begin
        count_s = count_r;
      end
    end else if (!RegLIVES_add_life_InLow) begin
      if ((state_r != ST_GAMEOVER) && (count_r < MAX_V)) begin
        count_s = count_r + ONE_LIFE;
      end else begin
        count_s = count_r;
      end
    end else begin
      count_s = count_r;
    end

    gameover_s = (count_s != ZERO_LIFE);
    grace_s    = (state_s == ST_GRACE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge RegLIVES_CLOCK_50) begin
    if (!RegLIVES_RESET_InLow) begin
      state_r     <= ST_GAMEOVER;
      count_r     <= ZERO_LIFE;
      grace_cnt_r <= GRACE_ZERO;
      lifelost_r  <= 1'b0;
      gameover_r  <= 1'b0;
      grace_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      grace_cnt_r <= grace_cnt_s;
      lifelost_r  <= lifelost_s;
      gameover_r  <= gameover_s;
      grace_r     <= grace_s;
    end
  end

  assign RegLIVES_data_OutBUS      = count_r;
  assign RegLIVES_gameover_OutLow  = gameover_r;
  assign RegLIVES_grace_OutHigh    = grace_r;
  assign RegLIVES_lifelost_OutHigh = lifelost_r;

endmodule

// File: tb/tb_sc_reg_lives_manager.sv
// Testbench for sc_reg_lives_manager. A second instance with LIVES_MAX=4
// covers load saturation below the width ceiling.
module tb_sc_reg_lives_manager;

  localparam int G    = 200;
  localparam int INIT = 3;
  localparam int MAX  = 7;

  logic       clk = 1'b0;
  logic       rst_n, clr_n, ld_n, sub_n, add_n;
  logic [2:0] data_in;
  logic [2:0] cnt, cnt2;
  logic       go_n, grace, ll, go_n2, grace2, ll2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: life count plus the absolute edge index at which grace ends.
  int m_count = 0;
  int m_gu    = 0;
  int m_ll    = 0;
  int edge_n  = 0;

  always #5 clk = ~clk;

  sc_reg_lives_manager dut (
    .RegLIVES_CLOCK_50(clk),
    .RegLIVES_RESET_InLow(rst_n),
    .RegLIVES_clear_InLow(clr_n),
    .RegLIVES_load_InLow(ld_n),
    .RegLIVES_data_InBUS(data_in),
    .RegLIVES_subtract_life_InLow(sub_n),
    .RegLIVES_add_life_InLow(add_n),
    .RegLIVES_data_OutBUS(cnt),
    .RegLIVES_gameover_OutLow(go_n),
    .RegLIVES_grace_OutHigh(grace),
    .RegLIVES_lifelost_OutHigh(ll)
  );

  sc_reg_lives_manager #(.LIVES_MAX(4), .GRACE_CYCLES(3)) dut_max4 (
    .RegLIVES_CLOCK_50(clk),
    .RegLIVES_RESET_InLow(rst_n),
    .RegLIVES_clear_InLow(clr_n),
    .RegLIVES_load_InLow(ld_n),
    .RegLIVES_data_InBUS(data_in),
    .RegLIVES_subtract_life_InLow(sub_n),
    .RegLIVES_add_life_InLow(add_n),
    .RegLIVES_data_OutBUS(cnt2),
    .RegLIVES_gameover_OutLow(go_n2),
    .RegLIVES_grace_OutHigh(grace2),
    .RegLIVES_lifelost_OutHigh(ll2)
  );

  function automatic logic [5:0] model_vec();
    return {3'(m_count), (m_count != 0), (edge_n < m_gu), (m_ll != 0)};
  endfunction

  // One clock edge: update the model from the sampled inputs, then settle.
  task automatic step();
    bit in_grace;
    @(posedge clk);
    edge_n++;
    in_grace = (m_count > 0) && ((edge_n - 1) < m_gu);
    m_ll = 0;
    if (!rst_n) begin
      m_count = 0; m_gu = 0;
    end else if (!clr_n) begin
      m_count = INIT; m_gu = 0;
    end else if (!ld_n) begin
      m_count = (int'(data_in) > MAX) ? MAX : int'(data_in); m_gu = 0;
    end else if (!sub_n) begin
      if (m_count > 0 && !in_grace) begin
        m_count = m_count - 1;
        m_ll = 1;
        m_gu = (m_count > 0) ? edge_n + G : 0;
      end
    end else if (!add_n) begin
      if (m_count > 0) m_count = (m_count + 1 > MAX) ? MAX : m_count + 1;
    end
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; clr_n = 1'b1; ld_n = 1'b1; sub_n = 1'b1; add_n = 1'b1; data_in = 3'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; clr_n = 1'b0; add_n = 1'b0; data_in = 3'd5;
    step(); step();
    idle();
    total_cnt++; if (cnt !== 3'd0) $display("FAIL reset_count got %0d want 0", cnt); else pass_cnt++;
    total_cnt++; if (go_n !== 1'b0) $display("FAIL reset_gameover got %b want 0", go_n); else pass_cnt++;
    total_cnt++; if (grace !== 1'b0) $display("FAIL reset_grace got %b want 0", grace); else pass_cnt++;
    total_cnt++; if (ll !== 1'b0) $display("FAIL reset_lifelost got %b want 0", ll); else pass_cnt++;
    clr_n = 1'b0; step(); clr_n = 1'b1;
    total_cnt++; if (cnt !== 3'd3) $display("FAIL clear_count got %0d want 3", cnt); else pass_cnt++;
    total_cnt++; if (go_n !== 1'b1) $display("FAIL clear_gameover got %b want 1", go_n); else pass_cnt++;
    total_cnt++; if (grace !== 1'b0) $display("FAIL clear_grace got %b want 0", grace); else pass_cnt++;
  endtask

  task automatic test_held_subtract();
    int lost[$];
    int gh = 0;
    int exp_edges[3] = '{1, 202, 403};
    idle(); clr_n = 1'b0; step(); clr_n = 1'b1;
    sub_n = 1'b0;
    for (int i = 1; i <= 500; i++) begin
      step();
      if (ll === 1'b1) lost.push_back(i);
      if (grace === 1'b1) gh++;
      total_cnt++;
      if ({cnt, go_n, grace, ll} !== model_vec())
        $display("FAIL held_sub_vec cycle %0d got %b want %b", i, {cnt, go_n, grace, ll}, model_vec());
      else pass_cnt++;
    end
    sub_n = 1'b1;
    total_cnt++;
    if (lost.size() != 3) $display("FAIL held_sub_pulses got %0d want 3", lost.size()); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (k >= lost.size() || lost[k] != exp_edges[k])
        $display("FAIL held_sub_edge%0d got %0d want %0d", k, (k < lost.size()) ? lost[k] : -1, exp_edges[k]);
      else pass_cnt++;
    end
    total_cnt++; if (gh != 2 * G) $display("FAIL held_sub_grace_cycles got %0d want %0d", gh, 2 * G); else pass_cnt++;
    total_cnt++; if (cnt !== 3'd0 || go_n !== 1'b0) $display("FAIL held_sub_final got %0d/%b want 0/0", cnt, go_n); else pass_cnt++;
  endtask

  task automatic test_add_in_grace();
    int dec_edge;
    bit fell = 1'b0;
    idle(); clr_n = 1'b0; step(); clr_n = 1'b1;
    sub_n = 1'b0; step(); sub_n = 1'b1; dec_edge = edge_n;
    total_cnt++; if (cnt !== 3'd2 || grace !== 1'b1) $display("FAIL aig_enter got %0d/%b want 2/1", cnt, grace); else pass_cnt++;
    repeat (10) step();
    add_n = 1'b0; step(); add_n = 1'b1;
    total_cnt++; if (cnt !== 3'd3) $display("FAIL aig_add got %0d want 3", cnt); else pass_cnt++;
    repeat (5) step();
    sub_n = 1'b0; step(); sub_n = 1'b1;
    total_cnt++; if (cnt !== 3'd3 || ll !== 1'b0) $display("FAIL aig_sub_ignored got %0d/%b want 3/0", cnt, ll); else pass_cnt++;
    for (int i = 0; i < 300 && !fell; i++) begin
      step();
      total_cnt++;
      if ({cnt, go_n, grace, ll} !== model_vec())
        $display("FAIL aig_vec edge %0d got %b want %b", edge_n, {cnt, go_n, grace, ll}, model_vec());
      else pass_cnt++;
      if (grace === 1'b0) fell = 1'b1;
    end
    total_cnt++;
    if (!fell || (edge_n - dec_edge) != G)
      $display("FAIL aig_grace_end got %0d want %0d", fell ? edge_n - dec_edge : -1, G);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [2:0] exp_seq[3] = '{3'd7, 3'd7, 3'd7};
    idle(); ld_n = 1'b0; data_in = 3'd6; step(); ld_n = 1'b1;
    total_cnt++; if (cnt !== 3'd6) $display("FAIL sat_load6 got %0d want 6", cnt); else pass_cnt++;
    add_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (cnt !== exp_seq[i]) $display("FAIL sat_add%0d got %0d want %0d", i, cnt, exp_seq[i]); else pass_cnt++;
    end
    add_n = 1'b1;
    ld_n = 1'b0; data_in = 3'd5; step(); ld_n = 1'b1;
    total_cnt++; if (cnt2 !== 3'd4) $display("FAIL sat_max4_load got %0d want 4", cnt2); else pass_cnt++;
    total_cnt++; if (cnt !== 3'd5) $display("FAIL sat_max7_load got %0d want 5", cnt); else pass_cnt++;
    add_n = 1'b0; step(); add_n = 1'b1;
    total_cnt++; if (cnt2 !== 3'd4) $display("FAIL sat_max4_add got %0d want 4", cnt2); else pass_cnt++;
  endtask

  task automatic test_same_edge();
    idle(); ld_n = 1'b0; data_in = 3'd2; step(); ld_n = 1'b1;
    sub_n = 1'b0; add_n = 1'b0; step(); sub_n = 1'b1; add_n = 1'b1;
    total_cnt++;
    if ({cnt, ll, grace} !== {3'd1, 1'b1, 1'b1}) $display("FAIL same_edge got %b want %b", {cnt, ll, grace}, {3'd1, 1'b1, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_abort_grace();
    idle(); ld_n = 1'b0; data_in = 3'd3; step(); ld_n = 1'b1;
    sub_n = 1'b0; step(); sub_n = 1'b1;
    repeat (20) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    total_cnt++;
    if ({cnt, go_n, grace} !== {3'd0, 1'b0, 1'b0}) $display("FAIL reset_mid_grace got %b want %b", {cnt, go_n, grace}, {3'd0, 1'b0, 1'b0});
    else pass_cnt++;
    ld_n = 1'b0; data_in = 3'd3; step(); ld_n = 1'b1;
    sub_n = 1'b0; step(); sub_n = 1'b1;
    repeat (20) step();
    clr_n = 1'b0; step(); clr_n = 1'b1;
    total_cnt++;
    if ({cnt, grace, ll} !== {3'd3, 1'b0, 1'b0}) $display("FAIL clear_mid_grace got %b want %b", {cnt, grace, ll}, {3'd3, 1'b0, 1'b0});
    else pass_cnt++;
    ld_n = 1'b0; data_in = 3'd0; step(); ld_n = 1'b1;
    add_n = 1'b0; step(); add_n = 1'b1;
    total_cnt++;
    if ({cnt, go_n} !== {3'd0, 1'b0}) $display("FAIL gameover_add got %b want %b", {cnt, go_n}, {3'd0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      clr_n   = ($urandom_range(0, 149) != 0);
      ld_n    = ($urandom_range(0, 79) != 0);
      sub_n   = ($urandom_range(0, 2) != 0);
      add_n   = ($urandom_range(0, 3) != 0);
      data_in = 3'($urandom_range(0, 7));
      step();
      total_cnt++;
      if ({cnt, go_n, grace, ll} !== model_vec())
        $display("FAIL random_vec edge %0d got %b want %b", edge_n, {cnt, go_n, grace, ll}, model_vec());
      else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_held_subtract();
    test_add_in_grace();
    test_saturation();
    test_same_edge();
    test_abort_grace();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
